// File: rtl/kof_keys_pkg.sv
// Shared keycode constants, action index enum and code lookup for the
// keyboard report builder and the keycode decoder.
package kof_keys_pkg;

  localparam int unsigned NUM_SLOTS = 6;
  localparam int unsigned NUM_ACT   = 9;
  localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_ACT);

  localparam logic [7:0] KEY_NONE       = 8'h00;
  localparam logic [7:0] KEY_ROLLOVER   = 8'h01;
  localparam logic [7:0] KEY_C1_MOVE_L  = 8'h04;
  localparam logic [7:0] KEY_C1_MOVE_R  = 8'h07;
  localparam logic [7:0] KEY_C1_ATTACK  = 8'h1A;
  localparam logic [7:0] KEY_C1_DEFENSE = 8'h16;
  localparam logic [7:0] KEY_C2_MOVE_L  = 8'h50;
  localparam logic [7:0] KEY_C2_MOVE_R  = 8'h4F;
  localparam logic [7:0] KEY_C2_ATTACK  = 8'h52;
  localparam logic [7:0] KEY_C2_DEFENSE = 8'h51;
  localparam logic [7:0] KEY_GAME_START = 8'h2C;

  typedef enum logic [IDX_W-1:0] {
    ACT_C1_MOVE_L  = 4'd0,
    ACT_C1_MOVE_R  = 4'd1,
    ACT_C1_ATTACK  = 4'd2,
    ACT_C1_DEFENSE = 4'd3,
    ACT_C2_MOVE_L  = 4'd4,
    ACT_C2_MOVE_R  = 4'd5,
    ACT_C2_ATTACK  = 4'd6,
    ACT_C2_DEFENSE = 4'd7,
    ACT_GAME_START = 4'd8
  } action_e;

  // Map an action index to its HID keycode; unused indices give KEY_NONE.
  function automatic logic [7:0] act_code(input logic [IDX_W-1:0] idx);
    logic [7:0] code;
    case (action_e'(idx))
      ACT_C1_MOVE_L:  code = KEY_C1_MOVE_L;
      ACT_C1_MOVE_R:  code = KEY_C1_MOVE_R;
      ACT_C1_ATTACK:  code = KEY_C1_ATTACK;
      ACT_C1_DEFENSE: code = KEY_C1_DEFENSE;
      ACT_C2_MOVE_L:  code = KEY_C2_MOVE_L;
      ACT_C2_MOVE_R:  code = KEY_C2_MOVE_R;
      ACT_C2_ATTACK:  code = KEY_C2_ATTACK;
      ACT_C2_DEFENSE: code = KEY_C2_DEFENSE;
      ACT_GAME_START: code = KEY_GAME_START;
      default:        code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keycode_slot_list.sv
// Ordered list of pressed keycodes: append on press, remove with compaction
// on release, optionally refilling the freed top slot in the same cycle.
module keycode_slot_list
  import kof_keys_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_insert,
  input  logic [7:0]             i_ins_code,
  input  logic                   i_remove,
  input  logic [7:0]             i_rem_code,
  input  logic                   i_append,
  input  logic [7:0]             i_app_code,
  output logic [8*NUM_SLOTS-1:0] o_list,
  output logic [CNT_W-1:0]       o_cnt
);

  logic [NUM_SLOTS-1:0][7:0] r_list;
  logic [CNT_W-1:0]          r_cnt;
  logic [NUM_SLOTS-1:0][7:0] w_list_d;
  logic [CNT_W-1:0]          w_cnt_d;
  logic [NUM_SLOTS-1:0][7:0] w_shift;
  logic                      w_found;

  // Every entry moved down one slot, with an empty code entering at the top.
  assign w_shift = {KEY_NONE, r_list[NUM_SLOTS-1:1]};

  // Next-state list: insert at the end, or remove-and-compact (plus refill).
  always_comb begin
    w_list_d = r_list;
    w_cnt_d  = r_cnt;
    w_found  = 1'b0;
    if (i_insert && (r_cnt < CNT_W'(NUM_SLOTS))) begin
      w_list_d[r_cnt] = i_ins_code;
      w_cnt_d         = r_cnt + CNT_W'(1);
    end else if (i_remove) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (!w_found && (k < int'(r_cnt)) && (r_list[k] == i_rem_code)) begin
          w_found = 1'b1;
        end
        // Entries at and above the removed position take their upper neighbour.
        if (w_found) begin
          w_list_d[k] = w_shift[k];
        end
      end
      if (w_found) begin
        if (i_append) begin
          w_list_d[r_cnt - CNT_W'(1)] = i_app_code;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
    end
  end

  // List and count registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_list <= '0;
      r_cnt  <= '0;
    end else begin
      r_list <= w_list_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign o_list = r_list;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/keycode_report_builder.sv
// Turns nine action levels into a six-slot HID keycode report with press
// ordering, six-key rollover signalling and a valid/ready output stage.
module keycode_report_builder
  import kof_keys_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_ACT-1:0]     i_act,
  input  logic                   i_report_ready,
  output logic [8*NUM_SLOTS-1:0] o_keycodes,
  output logic                   o_report_valid
);

  logic [NUM_ACT-1:0]     r_listed;
  logic [NUM_ACT-1:0]     r_ovf;
  logic [8*NUM_SLOTS-1:0] r_keycodes;
  logic                   r_report_valid;

  logic [NUM_ACT-1:0]     w_held;
  logic [NUM_ACT-1:0]     w_diff;
  logic                   w_evt;
  logic [IDX_W-1:0]       w_idx;
  logic [IDX_W-1:0]       w_ovf_idx;
  logic                   w_press;
  logic [NUM_ACT-1:0]     w_listed_d;
  logic [NUM_ACT-1:0]     w_ovf_d;
  logic                   w_insert;
  logic                   w_remove;
  logic                   w_append;
  logic [8*NUM_SLOTS-1:0] w_list;
  logic [CNT_W-1:0]       w_cnt;
  logic [8*NUM_SLOTS-1:0] w_snapshot;
  logic                   w_out_free;

  assign w_held = r_listed | r_ovf;
  assign w_diff = i_act ^ w_held;

  // Pick the lowest-index pending change and the lowest-index overflowed key.
  always_comb begin
    w_evt     = 1'b0;
    w_idx     = '0;
    w_ovf_idx = '0;
    for (int i = NUM_ACT - 1; i >= 0; i--) begin
      if (w_diff[i]) begin
        w_evt = 1'b1;
        w_idx = IDX_W'(i);
      end
      if (r_ovf[i]) begin
        w_ovf_idx = IDX_W'(i);
      end
    end
  end

  assign w_press = i_act[w_idx];

  // Decode the selected event into mask updates and list commands.
  always_comb begin
    w_listed_d = r_listed;
    w_ovf_d    = r_ovf;
    w_insert   = 1'b0;
    w_remove   = 1'b0;
    w_append   = 1'b0;
    if (w_evt) begin
      if (w_press) begin
        if (w_cnt < CNT_W'(NUM_SLOTS)) begin
          w_insert          = 1'b1;
          w_listed_d[w_idx] = 1'b1;
        end else begin
          w_ovf_d[w_idx] = 1'b1;
        end
      end else if (r_ovf[w_idx]) begin
        w_ovf_d[w_idx] = 1'b0;
      end else begin
        w_remove          = 1'b1;
        w_listed_d[w_idx] = 1'b0;
        // A freed slot is immediately taken by the lowest waiting overflow key.
        if (|r_ovf) begin
          w_append              = 1'b1;
          w_ovf_d[w_ovf_idx]    = 1'b0;
          w_listed_d[w_ovf_idx] = 1'b1;
        end
      end
    end
  end

  keycode_slot_list u_slot_list (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_insert   (w_insert),
    .i_ins_code (act_code(w_idx)),
    .i_remove   (w_remove),
    .i_rem_code (act_code(w_idx)),
    .i_append   (w_append),
    .i_app_code (act_code(w_ovf_idx)),
    .o_list     (w_list),
    .o_cnt      (w_cnt)
  );

  // Held-key masks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_listed <= '0;
      r_ovf    <= '0;
    end else begin
      r_listed <= w_listed_d;
      r_ovf    <= w_ovf_d;
    end
  end

  assign w_snapshot = (|r_ovf) ? {NUM_SLOTS{KEY_ROLLOVER}} : w_list;
  assign w_out_free = !r_report_valid || i_report_ready;

  // Output stage: load a changed snapshot when free, otherwise hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_keycodes     <= '0;
      r_report_valid <= 1'b0;
    end else if (w_out_free) begin
      if (w_snapshot != r_keycodes) begin
        r_keycodes     <= w_snapshot;
        r_report_valid <= 1'b1;
      end else begin
        r_report_valid <= 1'b0;
      end
    end
  end

  assign o_keycodes     = r_keycodes;
  assign o_report_valid = r_report_valid;

endmodule

// File: tb/tb_keycode_report_builder.sv
// Directed bench for keycode_report_builder.
module tb_keycode_report_builder;

  logic        clk;
  logic        rst;
  logic [8:0]  act;
  logic        ready;
  logic [47:0] keycodes;
  logic        valid;

  int n_checks;
  int n_fail;

  keycode_report_builder dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_act          (act),
    .i_report_ready (ready),
    .o_keycodes     (keycodes),
    .o_report_valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one rising edge; inputs change and outputs are sampled 1 unit later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    act   = 9'h000;
    ready = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    act = 9'h003;
    tick(4);
    n_checks++;
    if (keycodes !== 48'h0704) begin
      n_fail++;
      $display("FAIL reset_pre: keycodes=%h expected=%h", keycodes, 48'h0704);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (keycodes !== 48'h0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: keycodes=%h valid=%b expected 0/0", keycodes, valid);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    n_checks++;
    if (keycodes !== 48'h04 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_repress1: keycodes=%h valid=%b expected %h/1", keycodes, valid,
               48'h04);
    end
    tick(1);
    n_checks++;
    if (keycodes !== 48'h0704 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_repress2: keycodes=%h valid=%b expected %h/1", keycodes, valid,
               48'h0704);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    tick(2);
    act = 9'h004;
    tick(1);
    n_checks++;
    if (valid !== 1'b0 || keycodes !== 48'h0) begin
      n_fail++;
      $display("FAIL single_latency: keycodes=%h valid=%b expected 0/0", keycodes, valid);
    end
    tick(1);
    n_checks++;
    if (valid !== 1'b1 || keycodes !== 48'h00000000001A) begin
      n_fail++;
      $display("FAIL single_report: keycodes=%h valid=%b expected %h/1", keycodes, valid,
               48'h1A);
    end
    tick(1);
    n_checks++;
    if (valid !== 1'b0 || keycodes !== 48'h1A) begin
      n_fail++;
      $display("FAIL single_drop: keycodes=%h valid=%b expected %h/0", keycodes, valid,
               48'h1A);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1);
    act = 9'h003;
    tick(2);
    n_checks++;
    if (valid !== 1'b1 || keycodes !== 48'h04) begin
      n_fail++;
      $display("FAIL b2b_first: keycodes=%h valid=%b expected %h/1", keycodes, valid, 48'h04);
    end
    tick(1);
    n_checks++;
    if (valid !== 1'b1 || keycodes !== 48'h0704) begin
      n_fail++;
      $display("FAIL b2b_second: keycodes=%h valid=%b expected %h/1", keycodes, valid,
               48'h0704);
    end
    tick(1);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: valid=%b expected 0", valid);
    end
  endtask

  task automatic test_release_compact();
    do_reset();
    act = 9'h001;
    tick(1);
    act = 9'h003;
    tick(1);
    act = 9'h007;
    tick(3);
    n_checks++;
    if (keycodes !== 48'h1A0704) begin
      n_fail++;
      $display("FAIL compact_three: keycodes=%h expected %h", keycodes, 48'h1A0704);
    end
    act = 9'h005;
    tick(2);
    n_checks++;
    if (keycodes !== 48'h1A04 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL compact_release: keycodes=%h valid=%b expected %h/1", keycodes, valid,
               48'h1A04);
    end
    act = 9'h004;
    tick(3);
    n_checks++;
    if (keycodes !== 48'h1A) begin
      n_fail++;
      $display("FAIL compact_oldest: keycodes=%h expected %h", keycodes, 48'h1A);
    end
  endtask

  task automatic test_rollover();
    do_reset();
    act = 9'h07F;
    tick(10);
    n_checks++;
    if (keycodes !== 48'h010101010101) begin
      n_fail++;
      $display("FAIL rollover_on: keycodes=%h expected %h", keycodes, 48'h010101010101);
    end
    act = 9'h07E;
    tick(3);
    n_checks++;
    if (keycodes !== 48'h524F50161A07) begin
      n_fail++;
      $display("FAIL rollover_refill: keycodes=%h expected %h", keycodes, 48'h524F50161A07);
    end
    act = 9'h1FE;
    tick(4);
    n_checks++;
    if (keycodes !== 48'h010101010101) begin
      n_fail++;
      $display("FAIL rollover_two_ovf: keycodes=%h expected %h", keycodes, 48'h010101010101);
    end
    act = 9'h0FE;
    tick(4);
    n_checks++;
    if (keycodes !== 48'h010101010101) begin
      n_fail++;
      $display("FAIL rollover_ovf_release: keycodes=%h expected %h", keycodes,
               48'h010101010101);
    end
    act = 9'h07E;
    tick(4);
    n_checks++;
    if (keycodes !== 48'h524F50161A07) begin
      n_fail++;
      $display("FAIL rollover_clear: keycodes=%h expected %h", keycodes, 48'h524F50161A07);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    act   = 9'h001;
    tick(2);
    n_checks++;
    if (keycodes !== 48'h04 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: keycodes=%h valid=%b expected %h/1", keycodes, valid, 48'h04);
    end
    act = 9'h003;
    tick(1);
    act = 9'h007;
    tick(3);
    n_checks++;
    if (keycodes !== 48'h04 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: keycodes=%h valid=%b expected %h/1", keycodes, valid, 48'h04);
    end
    ready = 1'b1;
    tick(1);
    n_checks++;
    if (keycodes !== 48'h1A0704 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_latest: keycodes=%h valid=%b expected %h/1", keycodes, valid,
               48'h1A0704);
    end
    tick(1);
    n_checks++;
    if (valid !== 1'b0 || keycodes !== 48'h1A0704) begin
      n_fail++;
      $display("FAIL bp_drop: keycodes=%h valid=%b expected %h/0", keycodes, valid,
               48'h1A0704);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    act      = 9'h000;
    ready    = 1'b1;
    #3;
    n_checks++;
    if (keycodes !== 48'h0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL power_on_reset: keycodes=%h valid=%b expected 0/0", keycodes, valid);
    end
    tick(1);
    rst = 1'b0;
    test_reset();
    test_single_press();
    test_back_to_back();
    test_release_compact();
    test_rollover();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
